// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, imem address, and the IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] boot_pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stalls,
    output logic [15:0] perf_flushes,
`endif
    output logic        fetch_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   ifid_pc_nxt, ifid_instr_nxt;
    logic              ifid_valid_nxt, fault_nxt;
    logic              do_adv, do_stall, do_flush;

    // Next-state and next-register logic; redirect beats stall beats advance
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_pc_nxt    = ifid_pc;
        ifid_instr_nxt = ifid_instr;
        ifid_valid_nxt = ifid_valid;
        fault_nxt      = fetch_fault;
        do_adv         = 1'b0;
        do_stall       = 1'b0;
        do_flush       = 1'b0;
        case (state)
            ST_RUN: begin
                if (redirect) begin
                    do_flush       = 1'b1;
                    ifid_instr_nxt = NOP_INSTR;
                    ifid_valid_nxt = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_HALT;
                    end else begin
                        pc_nxt = redirect_pc;
                    end
                end else if (stall) begin
                    do_stall = 1'b1;
                end else begin
                    do_adv         = 1'b1;
                    pc_nxt         = pc + PC_STEP;
                    ifid_pc_nxt    = pc;
                    ifid_instr_nxt = imem_rdata;
                    ifid_valid_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                ifid_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= boot_pc & ~XLEN'(3);
            ifid_pc     <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ifid_pc     <= ifid_pc_nxt;
            ifid_instr  <= ifid_instr_nxt;
            ifid_valid  <= ifid_valid_nxt;
            fetch_fault <= fault_nxt;
        end
    end

    assign imem_addr     = pc;
    assign ifid_pc_plus4 = ifid_pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
    // Event counters stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (do_adv && (perf_fetched != {CNT_W{1'b1}}))
                perf_fetched <= perf_fetched + CNT_W'(1);
            if (do_stall && (perf_stalls != {CNT_W{1'b1}}))
                perf_stalls <= perf_stalls + CNT_W'(1);
            if (do_flush && (perf_flushes != {CNT_W{1'b1}}))
                perf_flushes <= perf_flushes + CNT_W'(1);
        end
    end
`else
    logic unused_perf_events;
    assign unused_perf_events = do_adv ^ do_stall ^ do_flush;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the pipelined processor: owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register consumed by decode. It sits directly upstream of decode/register-read and accepts stall requests from the hazard unit and branch/jump redirects resolved in EX. Branches are predicted not-taken, so fetch runs sequentially until a redirect arrives.

## Interface

- PC_STEP, 4: PC increment per fetched instruction (bytes)
- NOP_INSTR, 32'h0000_0000: encoding inserted into IF/ID on flush/reset

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- boot_pc  in  32  PC loaded while rst_n is low (bits [1:0] forced to 0)
- stall  in  1  hold PC and IF/ID this cycle
- redirect  in  1  taken branch/jump from EX; flush and reload PC
- redirect_pc  in  32  target address for redirect
- imem_addr  out  32  instruction-memory address (= PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- ifid_pc  out  32  PC of instruction in IF/ID
- ifid_pc_plus4  out  32  ifid_pc + PC_STEP (mod 2^32)
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_fault  out  1  sticky misaligned-redirect flag

## Operation

- FSM: RUN, HALT. Reset -> RUN. RUN -> HALT on redirect with redirect_pc[1:0] != 0. HALT exits only via reset.
- Priority per edge, in RUN: reset > redirect > stall > advance.
- Advance: pc <= pc + PC_STEP (wraps mod 2^32); IF/ID <= {pc, imem_rdata}, ifid_valid <= 1.
- Stall: pc, IF/ID, ifid_valid all held.
- Redirect (aligned): pc <= redirect_pc; ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc <= held value. Redirect overrides a simultaneous stall.
- Misaligned redirect: fetch_fault <= 1, state <= HALT, pc held, IF/ID flushed (NOP, valid 0).
- HALT: pc and IF/ID frozen, ifid_valid 0; stall/redirect ignored.
- ifid_pc_plus4 is combinational from ifid_pc.
- Reset values: pc = {boot_pc[31:2],2'b00}, ifid_pc = 0, ifid_pc_plus4 = PC_STEP, ifid_instr = NOP_INSTR, ifid_valid = 0, fetch_fault = 0, state = RUN, perf counters = 0.

## Timing

- imem_addr changes only on clk edges; imem_rdata sampled same cycle.
- Latency: address presented in cycle N -> instruction in IF/ID after edge ending cycle N.
- Redirect asserted in cycle N: cycle N+1 imem_addr = redirect_pc, ifid_valid = 0; cycle N+2 IF/ID holds target instruction (one bubble).
- Reset mid-operation: any edge with rst_n low discards in-flight state, regardless of stall/redirect.
- First instruction after reset release appears in IF/ID one edge after release.

## Configuration

- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (16), perf_stalls (16), perf_flushes (16); increment on advance, stall (RUN only), and redirect edges respectively; saturate at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; functional behaviour identical.

## Test plan

- Reset with boot_pc = 0x0000_0056, release: imem_addr = 0x54; next edge ifid_pc = 0x54, ifid_pc_plus4 = 0x58, ifid_instr = mem[0x54], ifid_valid = 1, imem_addr = 0x58.
- Stall 2 cycles with imem_addr = 0x58: imem_addr and IF/ID unchanged for both; after release ifid_pc = 0x58 next edge.
- Redirect to 0x100 with stall also high: next cycle imem_addr = 0x100, ifid_valid = 0, ifid_instr = NOP_INSTR; following edge ifid_pc = 0x100, valid 1.
- Wrap: boot_pc = 0xFFFF_FFFC, two advances: ifid_pc = 0xFFFF_FFFC then 0x0000_0000, ifid_pc_plus4 of first = 0x0000_0000.
- Redirect to 0x102: fetch_fault = 1, ifid_valid = 0, imem_addr frozen; further redirect to 0x200 ignored; reset clears fault and reloads boot_pc.
- With FETCH_PERF_CNT_EN: 5 advances, 2 stalls, 1 redirect -> perf_fetched = 5, perf_stalls = 2, perf_flushes = 1.
